grf_write_arbiter: RTL

- Shares the single GRF write port between two writers: the pipeline writeback stage (A, default priority) and the multi-cycle mult/div unit (B).
- B results are buffered in a small FIFO. A starvation guard stalls the pipeline so B can drain.
- A busy-register scoreboard for issued B operations feeds hazard/stall logic.
- Outputs drive the GRF writeEnable/writeReg/writeData/PCReg inputs directly.

---
 rtl/grf_write_arbiter.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/grf_write_arbiter.sv
// -----------------------------------------------------------------------------
// grf_write_arbiter
//
// Shares the single GRF write port between the pipeline writeback stage (A,
// default priority) and the multi-cycle mult/div unit (B). B results wait in
// a small FIFO. A starvation guard freezes the pipeline (stall_req) so the
// FIFO head can drain. A busy-register scoreboard tracks issued B operations
// for the hazard unit. The w_* outputs are registered and feed the GRF
// writeEnable/writeReg/writeData/PCReg inputs directly.
//
// Parameters:
//   FIFO_DEPTH   buffered B results (power of two, 2..8)
//   STARVE_LIMIT cycles the FIFO head may wait before a forced drain (1..15)
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   a_valid/a_ready            A write handshake; a_reg/a_data/a_pc fields
//   b_issue/b_issue_reg        MDU issue, marks destination busy
//   b_valid/b_ready            B result push into FIFO; b_reg/b_data/b_pc
//   stall_req                  pipeline freeze during a forced drain
//   busy                       outstanding B write per register
//   w_en/w_reg/w_data/w_pc     registered GRF write port
//
// Optional: define GRF_WRITE_TRACE_EN to print every committed write with
// its source tag ("A" or "B").
// -----------------------------------------------------------------------------
module grf_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic [31:0] a_pc,
  input  logic        b_issue,
  input  logic [4:0]  b_issue_reg,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  input  logic [31:0] b_pc,
  output logic        stall_req,
  output logic [31:0] busy,
  output logic        w_en,
  output logic [4:0]  w_reg,
  output logic [31:0] w_data,
  output logic [31:0] w_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]     STARVE_C = 4'(STARVE_LIMIT);

  typedef enum logic {
    IDLE,
    FORCE
  } state_t;

  state_t state, stateNext;

  // FIFO storage and bookkeeping
  logic [4:0]       fifoReg  [FIFO_DEPTH];
  logic [31:0]      fifoData [FIFO_DEPTH];
  logic [31:0]      fifoPc   [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count, countNext;
  logic [3:0]       starveCnt, starveNext;
  logic [31:0]      busyNext;

  logic fifoEmpty;
  logic aLive;
  logic doPop;
  logic doPush;

  // ---------------------------------------------------------------------------
  // Handshake outputs (state-derived)
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_req = (state == FORCE);
    a_ready   = reset && (state == IDLE);
    // Full check uses the registered count only; a same-cycle pop does not
    // open a slot.
    b_ready   = reset && (count < DEPTH_C);
  end

  // ---------------------------------------------------------------------------
  // Port selection
  // ---------------------------------------------------------------------------
  always_comb begin
    fifoEmpty = (count == '0);
    // Writes to $0 are accepted but never occupy the port.
    aLive     = a_valid && (a_reg != '0) && (state == IDLE);
    doPop     = !fifoEmpty && ((state == FORCE) || !aLive);
    doPush    = b_valid && b_ready && (b_reg != '0);
  end

  always_comb begin
    countNext = count;
    unique case ({doPush, doPop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts IDLE cycles in which a queued head was passed
  // over; saturates so a large limit cannot wrap back below the threshold.
  // ---------------------------------------------------------------------------
  always_comb begin
    starveNext = starveCnt;
    if (doPop || fifoEmpty) begin
      starveNext = '0;
    end else if ((state == IDLE) && (starveCnt != '1)) begin
      starveNext = starveCnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (starveNext == STARVE_C) stateNext = FORCE;
      FORCE:   if (doPop) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: set beats clear for the same register in one cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    busyNext = busy;
    if (doPop) begin
      busyNext[fifoReg[rdPtr]] = 1'b0;
    end
    if (b_issue && (b_issue_reg != '0)) begin
      busyNext[b_issue_reg] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Sequential bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      starveCnt <= '0;
      busy      <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count     <= countNext;
      starveCnt <= starveNext;
      busy      <= busyNext;
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoReg[wrPtr]  <= b_reg;
      fifoData[wrPtr] <= b_data;
      fifoPc[wrPtr]   <= b_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered GRF write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_en   <= 1'b0;
      w_reg  <= '0;
      w_data <= '0;
      w_pc   <= '0;
    end else begin
      w_en <= aLive || doPop;
      if (doPop) begin
        w_reg  <= fifoReg[rdPtr];
        w_data <= fifoData[rdPtr];
        w_pc   <= fifoPc[rdPtr];
      end else if (aLive) begin
        w_reg  <= a_reg;
        w_data <= a_data;
        w_pc   <= a_pc;
      end
    end
  end

`ifdef GRF_WRITE_TRACE_EN
  always @(posedge clk) begin
    if (reset && (aLive || doPop)) begin
      if (doPop) begin
        $display("%0d@%h: $%0d <= %h B", $time, fifoPc[rdPtr], fifoReg[rdPtr],
                 fifoData[rdPtr]);
      end else begin
        $display("%0d@%h: $%0d <= %h A", $time, a_pc, a_reg, a_data);
      end
    end
  end
`endif

endmodule
